// File: rtl/tt_sweep_checker.sv
// Exhaustive sweep checker: steps an N-bit stimulus through all 2^N codes, holds each
// for DWELL cycles, and compares the sampled function output against a latched truth table.
module tt_sweep_checker #(
    parameter int N     = 4,
    parameter int DWELL = 10,
    parameter int DW_W  = 4
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iSTART,
    input  logic [(1<<N)-1:0]   iEXP,
    input  logic                iY,
    output logic [N-1:0]        oVEC,
    output logic                oBUSY,
    output logic                oDONE,
    output logic                oPASS,
    output logic [N:0]          oERR_CNT,
    output logic [N-1:0]        oFIRST_ERR
);

    // state   | meaning
    // S_IDLE  | waiting for iSTART; results of the last sweep held
    // S_RUN   | stepping vectors, sampling iY on the last dwell cycle
    // S_DONE  | single-cycle completion pulse, oPASS valid from here on
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int            NV       = 1 << N;
    localparam logic [N-1:0]  VEC_LAST = N'(NV - 1);
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);

    state_t              state_q, state_d;
    logic [NV-1:0]       exp_q, exp_d;
    logic [N-1:0]        vec_q, vec_d;
    logic [DW_W-1:0]     dcnt_q, dcnt_d;
    logic [N:0]          err_q, err_d;
    logic [N-1:0]        first_q, first_d;
    logic                pass_q, pass_d;

    logic                dwell_end;
    logic                last_vec;
    logic                miss;

    assign dwell_end = (dcnt_q == DW_LAST);
    assign last_vec  = (vec_q == VEC_LAST);
    assign miss      = (iY != exp_q[vec_q]);

    // state register
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (iSTART) state_d = S_RUN;
            S_RUN:  if (dwell_end && last_vec) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // datapath next values
    always_comb begin
        exp_d   = exp_q;
        vec_d   = vec_q;
        dcnt_d  = dcnt_q;
        err_d   = err_q;
        first_d = first_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (iSTART) begin
                    exp_d   = iEXP;
                    vec_d   = '0;
                    dcnt_d  = '0;
                    err_d   = '0;
                    first_d = '0;
                    pass_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (!dwell_end) begin
                    dcnt_d = dcnt_q + 1'b1;
                end else begin
                    if (miss) begin
                        err_d = err_q + 1'b1;
                        if (err_q == '0) first_d = vec_q;
                    end
                    dcnt_d = '0;
                    if (!last_vec) begin
                        vec_d = vec_q + 1'b1;
                    end else begin
                        // final verdict must include the sample taken on this very edge
                        vec_d  = '0;
                        pass_d = (err_d == '0);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            exp_q   <= '0;
            vec_q   <= '0;
            dcnt_q  <= '0;
            err_q   <= '0;
            first_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            exp_q   <= exp_d;
            vec_q   <= vec_d;
            dcnt_q  <= dcnt_d;
            err_q   <= err_d;
            first_q <= first_d;
            pass_q  <= pass_d;
        end
    end

    // outputs
    always_comb begin
        oBUSY      = (state_q == S_RUN);
        oDONE      = (state_q == S_DONE);
        oVEC       = vec_q;
        oPASS      = pass_q;
        oERR_CNT   = err_q;
        oFIRST_ERR = first_q;
    end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: two instances (N=4/DWELL=10 and N=2/DWELL=1) checked every cycle
// against expectations derived from elapsed cycles since start and the injected fault mask.
module tb_tt_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, start_b;
    logic [15:0] exp_in_a;
    logic [3:0]  exp_in_b;
    logic [15:0] exp_m_a, flip_a;
    logic [3:0]  exp_m_b, flip_b;

    logic        y_a, y_b;
    logic [3:0]  vec_a;
    logic [1:0]  vec_b;
    logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [4:0]  err_a;
    logic [2:0]  err_b;
    logic [3:0]  first_a;
    logic [1:0]  first_b;

    // function under test: ideal truth table with selected vectors inverted
    assign y_a = exp_m_a[vec_a] ^ flip_a[vec_a];
    assign y_b = exp_m_b[vec_b] ^ flip_b[vec_b];

    tt_sweep_checker #(.N(4), .DWELL(10), .DW_W(4)) u_dut_a (
        .iCLK(clk), .iRST(rst), .iSTART(start_a), .iEXP(exp_in_a), .iY(y_a),
        .oVEC(vec_a), .oBUSY(busy_a), .oDONE(done_a), .oPASS(pass_a),
        .oERR_CNT(err_a), .oFIRST_ERR(first_a)
    );

    tt_sweep_checker #(.N(2), .DWELL(1), .DW_W(4)) u_dut_b (
        .iCLK(clk), .iRST(rst), .iSTART(start_b), .iEXP(exp_in_b), .iY(y_b),
        .oVEC(vec_b), .oBUSY(busy_b), .oDONE(done_b), .oPASS(pass_b),
        .oERR_CNT(err_b), .oFIRST_ERR(first_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    function automatic int pop_below(input logic [15:0] f, input int m);
        int c = 0;
        for (int i = 0; i < m; i++) c += int'(f[i]);
        return c;
    endfunction

    function automatic int first_below(input logic [15:0] f, input int m);
        for (int i = 0; i < m; i++) if (f[i]) return i;
        return 0;
    endfunction

    // j = number of clock edges since the start edge (0 = cycle right after start)
    task automatic check_outs(input string who, input int nv, input int d, input logic [15:0] f,
                              input int j, input int vec, input int busy, input int done,
                              input int pass, input int err, input int first);
        int m, e_vec, e_busy, e_done, e_pass;
        if (j < nv * d) begin
            m = j / d; e_vec = m; e_busy = 1; e_done = 0; e_pass = 0;
        end else begin
            m = nv; e_vec = 0; e_busy = 0; e_done = (j == nv * d) ? 1 : 0;
            e_pass = (pop_below(f, nv) == 0) ? 1 : 0;
        end
        check_val($sformatf("%s.vec@%0d", who, j), vec, e_vec);
        check_val($sformatf("%s.busy@%0d", who, j), busy, e_busy);
        check_val($sformatf("%s.done@%0d", who, j), done, e_done);
        check_val($sformatf("%s.pass@%0d", who, j), pass, e_pass);
        check_val($sformatf("%s.err@%0d", who, j), err, pop_below(f, m));
        check_val($sformatf("%s.first@%0d", who, j), first, first_below(f, m));
    endtask

    task automatic check_zero(input string who, input int vec, input int busy, input int done,
                              input int pass, input int err, input int first);
        check_val({who, ".rst_vec"}, vec, 0);
        check_val({who, ".rst_busy"}, busy, 0);
        check_val({who, ".rst_done"}, done, 0);
        check_val({who, ".rst_pass"}, pass, 0);
        check_val({who, ".rst_err"}, err, 0);
        check_val({who, ".rst_first"}, first, 0);
    endtask

    // called at a negedge; the following posedge is the start edge
    task automatic sweep_a(input logic [15:0] e, input logic [15:0] f, input bit hold,
                           input bit disturb, input int rst_at, input int tail);
        exp_m_a  = e;
        flip_a   = f;
        exp_in_a = e;
        start_a  = 1'b1;
        for (int j = 0; j <= 160 + tail; j++) begin
            @(negedge clk);
            check_outs("A", 16, 10, f, j, int'(vec_a), int'(busy_a), int'(done_a),
                       int'(pass_a), int'(err_a), int'(first_a));
            if (j == rst_at) begin
                rst = 1'b1;
                #1;
                check_zero("A", int'(vec_a), int'(busy_a), int'(done_a), int'(pass_a),
                           int'(err_a), int'(first_a));
                start_a = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                check_zero("A_post", int'(vec_a), int'(busy_a), int'(done_a), int'(pass_a),
                           int'(err_a), int'(first_a));
                return;
            end
            if (j == 0 && !hold) start_a = 1'b0;
            if (disturb && j == 50) start_a = 1'b1;
            if (disturb && j == 51 && !hold) start_a = 1'b0;
            exp_in_a = (disturb && j >= 60) ? 16'h0000 : 16'($urandom);
        end
    endtask

    task automatic sweep_b(input logic [3:0] e, input logic [3:0] f, input int tail);
        exp_m_b  = e;
        flip_b   = f;
        exp_in_b = e;
        start_b  = 1'b1;
        for (int j = 0; j <= 4 + tail; j++) begin
            @(negedge clk);
            check_outs("B", 4, 1, {12'h000, f}, j, int'(vec_b), int'(busy_b), int'(done_b),
                       int'(pass_b), int'(err_b), int'(first_b));
            if (j == 0) start_b = 1'b0;
            exp_in_b = 4'($urandom);
        end
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        exp_in_a = '0; exp_in_b = '0;
        exp_m_a = '0; flip_a = '0; exp_m_b = '0; flip_b = '0;
        repeat (2) @(negedge clk);
        check_zero("A_init", int'(vec_a), int'(busy_a), int'(done_a), int'(pass_a),
                   int'(err_a), int'(first_a));
        check_zero("B_init", int'(vec_b), int'(busy_b), int'(done_b), int'(pass_b),
                   int'(err_b), int'(first_b));
        rst = 1'b0;
        @(negedge clk);

        sweep_a(16'hA5C3, 16'h0000, 1'b0, 1'b0, -1, 3);
        sweep_a(16'hA5C3, 16'h1020, 1'b0, 1'b0, -1, 5);
        sweep_a(16'hA5C3, 16'h0000, 1'b0, 1'b1, -1, 2);
        sweep_a(16'hA5C3, 16'h1020, 1'b0, 1'b0, 73, 0);
        sweep_a(16'hA5C3, 16'h0000, 1'b0, 1'b0, -1, 2);
        repeat (4) sweep_a(16'($urandom), 16'($urandom & $urandom & $urandom), 1'b0, 1'b0, -1, 1);
        sweep_a(16'($urandom), 16'h8001, 1'b0, 1'b0, -1, 1);

        // back-to-back sweeps with start held; second one must clear the error count
        sweep_a(16'($urandom), 16'h4810, 1'b1, 1'b0, -1, 1);
        sweep_a(16'hA5C3, 16'h0000, 1'b1, 1'b0, -1, 1);
        start_a = 1'b0;
        @(negedge clk);

        sweep_b(4'b0110, 4'h0, 2);
        sweep_b(4'b0110, 4'hF, 2);
        repeat (6) sweep_b(4'($urandom), 4'($urandom), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
Parametrised, clocked successor to our exhaustive 4-input combinational stimulus benches. It drives every one of the 2^N input combinations onto an N-bit vector bus and holds each for a programmable number of cycles. It samples the function-under-test output at the end of each hold and compares it against a latched expected truth table. It reports pass/fail, the mismatch count and the first failing vector index. It sits between a combinational function block and the board/lab status logic.

Parameters:
N, 4, number of function inputs (1..8); sweep length = 2^N vectors.
DWELL, 10, clock cycles each vector is held (>=1); the sample is taken on the last cycle.
DW_W, 4, width of the dwell counter (must hold DWELL-1).

Ports:
iCLK  input  1  clock; all state updates on its rising edge.
iRST  input  1  reset, asynchronous, active-high.
iSTART  input  1  starts a sweep when sampled high in IDLE.
iEXP  input  2^N  expected truth table; bit k is the expected output for vector k. Latched at start.
iY  input  1  output of the function under test, driven combinationally from oVEC.
oVEC  output  N  current stimulus vector (bit N-1 = MSB, equivalent to iA).
oBUSY  output  1  high while a sweep runs.
oDONE  output  1  one-cycle pulse when a sweep completes.
oPASS  output  1  result of the last completed sweep; held until the next start or reset.
oERR_CNT  output  N+1  number of mismatching vectors in the last or current sweep.
oFIRST_ERR  output  N  index of the first mismatching vector; 0 if none.

Behaviour:
- Reset (iRST=1, asynchronous): state=IDLE; oVEC=0, oBUSY=0, oDONE=0, oPASS=0, oERR_CNT=0, oFIRST_ERR=0; internal exp register=0, dwell counter=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - oBUSY=0.
  - If iSTART=1 at edge k: latch iEXP; vec=0; dcnt=0; oERR_CNT=0; oFIRST_ERR=0; oPASS=0; go to RUN (oBUSY=1 from edge k).
- RUN:
  - On each edge, if dcnt != DWELL-1, then dcnt++.
  - Otherwise sample iY and compare with exp[vec]:
    - On mismatch: oERR_CNT++. If oERR_CNT was 0, oFIRST_ERR=vec.
    - If vec != 2^N-1: vec++ and dcnt=0.
    - Otherwise go to DONE.
  - Vector v is driven from edge k+v*DWELL to edge k+(v+1)*DWELL. The last sample is taken at edge k+2^N*DWELL.
- DONE (exactly one cycle):
  - oDONE=1, oBUSY=0.
  - oPASS = (oERR_CNT==0), computed including the final sample.
  - oVEC returns to 0.
  - Next edge goes to IDLE.
- iSTART in RUN or DONE is ignored. iEXP changes after the start are ignored (the latched copy is used).
- iSTART held high continuously gives back-to-back sweeps: DONE → IDLE → RUN, one idle cycle between sweeps.
- oERR_CNT cannot overflow: N+1 bits holds 2^N.
- DWELL=1: a new vector every cycle, each sampled at the edge ending its single cycle.
- Reset mid-sweep: immediate return to IDLE with all reset values; there is no partial oDONE.
- The function under test must settle within DWELL cycles. No synchroniser is applied to iY (same clock domain).

Test Plan:
1. N=4, DWELL=10, iEXP=16'hA5C3, ideal model iY=iEXP[oVEC]; START pulse at edge 0 → oVEC steps 0..15 every 10 cycles; oDONE pulse at cycle 161; oPASS=1, oERR_CNT=0, oFIRST_ERR=0.
2. Same setup, model output inverted at vectors 5 and 12 → oERR_CNT=2, oFIRST_ERR=5, oPASS=0; values hold after oDONE until the next START.
3. START re-pulsed at cycle 50 and iEXP changed to 16'h0000 at cycle 60 → both ignored; result is identical to scenario 1.
4. iRST pulsed at cycle 73 (mid vector 7) → all outputs 0 within the same cycle, no oDONE; a new START completes as in scenario 1.
5. N=2, DWELL=1, iEXP=4'b0110, model output always inverted → sweep lasts 4 cycles; oERR_CNT=4, oFIRST_ERR=0, oPASS=0.
6. iSTART held high for 400 cycles with the ideal model → two consecutive sweeps; oDONE pulses at cycles 161 and 323; oERR_CNT is cleared at the second start.
